cgen_bank: RTL and testbench
============================

// Module: cgen_bank
// PURPOSE
//  Bank of W independent, synchronous, generalised Muller C-elements for clocked netlist models.
//  Each channel has N inputs, per-input inversion, and asymmetric rise/fall input sets.
//  Also provides per-channel pre-capture (next) values, bank completion flags and a
//  saturating count of cycles in which any channel switched.
//  Replaces ad-hoc 2-input C/NC cells in generated models of wide asynchronous datapaths.
// PARAMETERS
//  W        4          number of channels
//  N        2          inputs per channel (>=1)
//  INV      {N{1'b0}}  N-bit mask; bit j=1 -> input j inverted before use (all ones == NC-style)
//  UP_MASK  {N{1'b1}}  N-bit mask; inputs that must all be 1 (after INV) to set Q
//  DN_MASK  {N{1'b1}}  N-bit mask; inputs that must all be 0 (after INV) to clear Q
//  RST_VAL  {W{1'b0}}  W-bit value loaded into Q on RS
//  CW       8          width of switch counter EVCNT
// PORTS
//  CK      in   1      clock, rising edge
//  RS      in   1      synchronous reset, active-high
//  ST      in   1      synchronous set, active-high; Q <= all ones
//  ENA     in   1      capture enable
//  A       in   W*N    inputs; channel c, input j at A[c*N+j]
//  Q       out  W      C-element states (registered)
//  PRECAP  out  W      combinational next value per channel
//  ALL_HI  out  1      Q == all ones (combinational from Q)
//  ALL_LO  out  1      Q == all zeros (combinational from Q)
//  EVCNT   out  CW     saturating count of switching cycles (registered)
// BEHAVIOUR
//  Per channel c: a[j] = A[c*N+j] ^ INV[j].
//   rise[c] = AND of a[j] over j with UP_MASK[j]=1.
//   fall[c] = AND of ~a[j] over j with DN_MASK[j]=1.
//   An empty mask makes that term constant 1.
//  Conflict: rise[c] && fall[c] (only possible with disjoint masks) -> treated as hold.
//  PRECAP[c] = rise&~fall ? 1 : fall&~rise ? 0 : Q[c]. Ignores ENA/RS/ST, same as C2.
//  Priority at each CK rising edge (all synchronous):
//   1) RS: Q <= RST_VAL, EVCNT <= 0
//   2) ST: Q <= {W{1'b1}}; EVCNT unchanged
//   3) ENA: Q <= PRECAP
//   4) else: Q holds
//  Switch counting:
//   - EVCNT += 1 on a cycle when ENA=1, RS=0, ST=0 and PRECAP != Q.
//   - Saturates at 2^CW-1; never wraps.
//   - ST-induced changes are not counted.
//  Latency:
//   - Input to Q: 1 cycle.
//   - Input to PRECAP: 0 cycles.
//   - Q to ALL_HI/ALL_LO: 0 cycles.
//  Reset values: Q=RST_VAL, EVCNT=0, ALL_HI/ALL_LO follow RST_VAL.
//  PRECAP after reset reflects current A against Q=RST_VAL.
//  RS mid-operation: any pending transition is discarded and Q=RST_VAL next cycle.
//  RS and ST together: RS wins.
//  No X-propagation filtering: X on a participating input gives X in PRECAP.
//  Channels are fully independent; no cross-channel arbitration.
// TESTING
//  T1 default W=4,N=2, RS=1 one cycle -> Q=0000, EVCNT=0, ALL_LO=1, ALL_HI=0.
//  T2 ENA=1; ch0 A=11 -> PRECAP[0]=1 same cycle, Q[0]=1 next edge, EVCNT=1.
//     Then A=01 -> Q[0] holds 1, EVCNT stays 1.
//  T3 ENA=0; ch1 A=11 for 3 cycles -> Q[1]=0, PRECAP[1]=1, EVCNT unchanged.
//     Raise ENA -> Q[1]=1 next edge.
//  T4 INV=2'b11 (NC2 mode), A=00 on all channels -> Q=1111 next edge, ALL_HI=1.
//     Then A=11 -> Q=0000.
//  T5 UP_MASK=01, DN_MASK=10, ch0 A[1:0]=01:
//     - rise=1, fall=1 -> conflict, Q[0] holds.
//     - A=11 -> rise only, Q[0]=1.
//     - A=00 -> fall only, Q[0]=0.
//  T6 CW=2, toggle ch0 every cycle for 6 cycles -> EVCNT 1,2,3,3,3,3 (saturates).
//     RS and ST together -> Q=RST_VAL, EVCNT=0.
//     ST alone -> Q=1111, EVCNT unchanged.

Source files
------------

// File: rtl/cgen_bank.sv
// Bank of W synchronous generalised Muller C-elements with per-input inversion,
// asymmetric rise/fall input sets, completion flags and a saturating switch counter.
module cgen_bank #(
  parameter int                W       = 4,
  parameter int                N       = 2,
  parameter logic [N-1:0]      INV     = {N{1'b0}},
  parameter logic [N-1:0]      UP_MASK = {N{1'b1}},
  parameter logic [N-1:0]      DN_MASK = {N{1'b1}},
  parameter logic [W-1:0]      RST_VAL = {W{1'b0}},
  parameter int                CW      = 8
) (
  input  logic             CK,
  input  logic             RS,
  input  logic             ST,
  input  logic             ENA,
  input  logic [W*N-1:0]   A,
  output logic [W-1:0]     Q,
  output logic [W-1:0]     PRECAP,
  output logic             ALL_HI,
  output logic             ALL_LO,
  output logic [CW-1:0]    EVCNT
);

  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] evcnt_q, evcnt_d;
  logic [W-1:0]  rise, fall, precap;
  logic          a_bit;

  // Empty masks leave the term at its AND identity, so it reads as constant 1.
  always_comb begin
    rise   = '1;
    fall   = '1;
    precap = '0;
    a_bit  = 1'b0;
    for (int c = 0; c < W; c++) begin
      for (int j = 0; j < N; j++) begin
        a_bit   = A[c*N+j] ^ INV[j];
        rise[c] = rise[c] & (a_bit | ~UP_MASK[j]);
        fall[c] = fall[c] & (~a_bit | ~DN_MASK[j]);
      end
      // Both terms active is a conflict and behaves as hold.
      if (rise[c] && !fall[c])
        precap[c] = 1'b1;
      else if (fall[c] && !rise[c])
        precap[c] = 1'b0;
      else
        precap[c] = q_q[c];
    end
  end

  always_comb begin
    q_d     = q_q;
    evcnt_d = evcnt_q;
    if (ST) begin
      q_d = {W{1'b1}};
    end else if (ENA) begin
      q_d = precap;
      if ((precap != q_q) && (evcnt_q != {CW{1'b1}}))
        evcnt_d = evcnt_q + CW'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (RS) begin
      q_q     <= RST_VAL;
      evcnt_q <= '0;
    end else begin
      q_q     <= q_d;
      evcnt_q <= evcnt_d;
    end
  end

  assign Q      = q_q;
  assign PRECAP = precap;
  assign ALL_HI = &q_q;
  assign ALL_LO = ~|q_q;
  assign EVCNT  = evcnt_q;

endmodule

// File: tb/tb_cgen_bank.sv
// Directed bench for cgen_bank: four parameterisations share one stimulus stream,
// each test resets the bank and checks the instance it targets.
module tb_cgen_bank;

  logic       ck = 1'b0;
  logic       rs, st, ena;
  logic [7:0] a;

  logic [3:0] q_def, pc_def, q_nc, pc_nc, q_msk, pc_msk, q_sat, pc_sat;
  logic       hi_def, lo_def, hi_nc, lo_nc, hi_msk, lo_msk, hi_sat, lo_sat;
  logic [7:0] ev_def, ev_nc, ev_msk;
  logic [1:0] ev_sat;

  int errs   = 0;
  int checks = 0;

  always #5 ck = ~ck;

  cgen_bank u_def (
    .CK(ck), .RS(rs), .ST(st), .ENA(ena), .A(a),
    .Q(q_def), .PRECAP(pc_def), .ALL_HI(hi_def), .ALL_LO(lo_def), .EVCNT(ev_def)
  );

  cgen_bank #(.INV(2'b11)) u_nc (
    .CK(ck), .RS(rs), .ST(st), .ENA(ena), .A(a),
    .Q(q_nc), .PRECAP(pc_nc), .ALL_HI(hi_nc), .ALL_LO(lo_nc), .EVCNT(ev_nc)
  );

  cgen_bank #(.UP_MASK(2'b01), .DN_MASK(2'b10)) u_msk (
    .CK(ck), .RS(rs), .ST(st), .ENA(ena), .A(a),
    .Q(q_msk), .PRECAP(pc_msk), .ALL_HI(hi_msk), .ALL_LO(lo_msk), .EVCNT(ev_msk)
  );

  cgen_bank #(.CW(2)) u_sat (
    .CK(ck), .RS(rs), .ST(st), .ENA(ena), .A(a),
    .Q(q_sat), .PRECAP(pc_sat), .ALL_HI(hi_sat), .ALL_LO(lo_sat), .EVCNT(ev_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rs = 1'b1; st = 1'b0; ena = 1'b0; a = 8'h00;
    tick();
    rs = 1'b0;
    #1;
  endtask

  initial begin
    rs = 1'b1; st = 1'b0; ena = 1'b0; a = 8'h00;

    // T1: reset state
    do_reset();
    check("t1_q",      q_def,  4'b0000);
    check("t1_ev",     ev_def, 8'd0);
    check("t1_all_lo", lo_def, 1'b1);
    check("t1_all_hi", hi_def, 1'b0);
    check("t1_nc_pc",  pc_nc,  4'b1111);

    // T2: ch0 rises, then mixed inputs hold
    ena = 1'b1; a = 8'b0000_0011; #1;
    check("t2_pc_same_cycle", pc_def, 4'b0001);
    check("t2_q_before_edge", q_def,  4'b0000);
    tick();
    check("t2_q_set",  q_def,  4'b0001);
    check("t2_ev1",    ev_def, 8'd1);
    a = 8'b0000_0010;
    tick();
    check("t2_q_hold", q_def,  4'b0001);
    check("t2_ev_hold", ev_def, 8'd1);

    // T3: ENA low blocks capture while PRECAP still reflects inputs
    ena = 1'b0; a = 8'b0000_1110;
    tick(); tick(); tick();
    check("t3_q_blocked", q_def,  4'b0001);
    check("t3_pc",        pc_def, 4'b0011);
    check("t3_ev",        ev_def, 8'd1);
    ena = 1'b1;
    tick();
    check("t3_q_capture", q_def,  4'b0011);
    check("t3_ev2",       ev_def, 8'd2);

    // T4: inverted inputs (NC2 mode)
    do_reset();
    ena = 1'b1; a = 8'h00;
    tick();
    check("t4_q_all1", q_nc,  4'b1111);
    check("t4_all_hi", hi_nc, 1'b1);
    a = 8'hFF;
    tick();
    check("t4_q_all0", q_nc,  4'b0000);
    check("t4_all_lo", lo_nc, 1'b1);

    // T5: disjoint masks, conflict holds
    do_reset();
    ena = 1'b1; a = 8'h01; #1;
    check("t5_conflict_pc0", pc_msk, 4'b0000);
    tick();
    check("t5_conflict_q0", q_msk, 4'b0000);
    a = 8'h03;
    tick();
    check("t5_rise", q_msk, 4'b0001);
    a = 8'h01;
    tick();
    check("t5_conflict_q1", q_msk, 4'b0001);
    a = 8'h00;
    tick();
    check("t5_fall", q_msk, 4'b0000);

    // T6: counter saturation at CW=2
    do_reset();
    ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? 8'h03 : 8'h00;
      tick();
      check($sformatf("t6_ev_%0d", i), ev_sat, (i < 3) ? 2'(i + 1) : 2'd3);
    end

    // RS with ST: reset wins
    rs = 1'b1; st = 1'b1; a = 8'h03;
    tick();
    check("t6_rsst_q",  q_sat,  4'b0000);
    check("t6_rsst_ev", ev_sat, 2'd0);

    // ST alone with a pending ENA change: Q all ones, no count
    rs = 1'b0; st = 1'b1; ena = 1'b1; a = 8'hFF;
    tick();
    check("t6_st_q",      q_sat,  4'b1111);
    check("t6_st_ev",     ev_sat, 2'd0);
    check("t6_st_all_hi", hi_def, 1'b1);
    st = 1'b0; a = 8'h00;
    tick();
    check("t6_after_st_q",  q_sat,  4'b0000);
    check("t6_after_st_ev", ev_sat, 2'd1);

    // RS mid-operation discards a pending transition
    a = 8'hFF; rs = 1'b1;
    tick();
    rs = 1'b0;
    check("t6_rs_mid_q",  q_def,  4'b0000);
    check("t6_rs_mid_ev", ev_def, 8'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
